sel_mux_scan: RTL and testbench

- Parametrised, registered N-channel selector. Successor to the fixed 8-to-1, 4-bit combinational select.
- Adds a registered output stage with a valid/ready handshake.
- Adds an auto-scan mode that steps through the channels round-robin.
- Adds out-of-range select detection.
- Sits between parallel data sources and a single downstream consumer.

---
 rtl/sel_pkg.sv | 21 ++
 rtl/sel_scan_ptr.sv | 64 ++++++
 rtl/sel_mux_scan.sv | 150 +++++++++++++++
 tb/tb_sel_mux_scan.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sel_pkg.sv
// Shared encodings and width helper for the registered N-channel selector.
// The optional masked-scan feature is enabled with the SEL_SCAN_MASK_EN macro.
package sel_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } sel_state_e;

  function automatic int sel_width(input int channels);
    if (channels < 2) begin
      return 1;
    end else begin
      return $clog2(channels);
    end
  endfunction

endpackage

// File: rtl/sel_scan_ptr.sv
// Next scan pointer: plain increment-and-wrap, or a masked round-robin search
// when SEL_SCAN_MASK_EN is defined.
module sel_scan_ptr
  import sel_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int SELW     = sel_width(CHANNELS)
) (
`ifdef SEL_SCAN_MASK_EN
  input  logic [CHANNELS-1:0] ch_mask,
`endif
  input  logic [SELW-1:0]     cur_ptr,
  output logic [SELW-1:0]     next_ptr,
  output logic [SELW-1:0]     first_ptr,
  output logic                any_enabled
);

`ifdef SEL_SCAN_MASK_EN
  // Nearest enabled channel after cur_ptr; smallest distance is assigned last and wins
  always_comb begin
    int idx_s;
    idx_s    = 0;
    next_ptr = cur_ptr;
    for (int k = CHANNELS; k >= 1; k--) begin
      idx_s = (int'(cur_ptr) + k) % CHANNELS;
      if (ch_mask[idx_s]) begin
        next_ptr = SELW'(idx_s);
      end else begin
        next_ptr = next_ptr;
      end
    end
  end

  // Lowest enabled channel is where a fresh scan starts
  always_comb begin
    first_ptr = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (ch_mask[k]) begin
        first_ptr = SELW'(k);
      end else begin
        first_ptr = first_ptr;
      end
    end
  end

  assign any_enabled = |ch_mask;
`else
  localparam logic [SELW-1:0] CH_LAST = SELW'(CHANNELS - 1);

  // Sequential step with wrap from the last channel back to zero
  always_comb begin
    next_ptr = '0;
    if (cur_ptr == CH_LAST) begin
      next_ptr = '0;
    end else begin
      next_ptr = cur_ptr + SELW'(1);
    end
  end

  assign first_ptr   = '0;
  assign any_enabled = 1'b1;
`endif

endmodule

// File: rtl/sel_mux_scan.sv
// Registered N-channel selector with valid/ready output, direct or round-robin
// scan channel choice, and out-of-range select flag. Optional: SEL_SCAN_MASK_EN.
module sel_mux_scan
  import sel_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 8,
  parameter int SELW     = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SELW-1:0]           sel_in,
  input  logic                      mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          dout,
  output logic [SELW-1:0]           dout_ch,
  output logic                      out_valid,
  input  logic                      out_ready,
`ifdef SEL_SCAN_MASK_EN
  input  logic [CHANNELS-1:0]       ch_mask,
`endif
  output logic                      sel_err
);

  localparam logic [SELW-1:0] CH_LAST = SELW'(CHANNELS - 1);

  sel_state_e       state_r, state_s;
  logic             mode_q_r;
  logic [SELW-1:0]  ptr_r;
  logic [WIDTH-1:0] dout_r;
  logic [SELW-1:0]  dout_ch_r;
  logic             sel_err_r;

  logic             scan_s, entering_s, oor_s, oor_raw_s;
  logic             ready_s, capture_s, any_en_s;
  logic [SELW-1:0]  scan_ch_s, pick_ch_s, next_ptr_s, first_ptr_s;
  logic [WIDTH-1:0] data_s;

  sel_scan_ptr #(
    .CHANNELS (CHANNELS),
    .SELW     (SELW)
  ) u_ptr (
`ifdef SEL_SCAN_MASK_EN
    .ch_mask     (ch_mask),
`endif
    .cur_ptr     (scan_ch_s),
    .next_ptr    (next_ptr_s),
    .first_ptr   (first_ptr_s),
    .any_enabled (any_en_s)
  );

  // With a power-of-two channel count every select code is a real channel
  generate
    if (CHANNELS == (1 << SELW)) begin : g_full_range
      assign oor_raw_s = 1'b0;
    end else begin : g_part_range
      assign oor_raw_s = (sel_in > CH_LAST);
    end
  endgenerate

  // Channel choice: entering scan restarts at the first channel regardless of ptr_r
  always_comb begin
    scan_s     = (mode == MODE_SCAN);
    entering_s = scan_s && (mode_q_r == MODE_DIRECT);
    scan_ch_s  = entering_s ? first_ptr_s : ptr_r;
    pick_ch_s  = scan_s ? scan_ch_s : sel_in;
    oor_s      = !scan_s && oor_raw_s;
  end

  // Data mux; an out-of-range select matches no channel and yields zero
  always_comb begin
    data_s = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (pick_ch_s == SELW'(k)) begin
        data_s = din[k*WIDTH +: WIDTH];
      end else begin
        data_s = data_s;
      end
    end
  end

  // Handshake: no skid buffer, and an empty scan mask blocks captures
  always_comb begin
    ready_s   = ((state_r == ST_EMPTY) || out_ready) && (!scan_s || any_en_s);
    capture_s = in_valid && ready_s;
  end

  // Output-stage next state
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (capture_s) begin
          state_s = ST_FULL;
        end else begin
          state_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (capture_s) begin
          state_s = ST_FULL;
        end else if (out_ready) begin
          state_s = ST_EMPTY;
        end else begin
          state_s = ST_FULL;
        end
      end
      default: state_s = ST_EMPTY;
    endcase
  end

  // State, mode history and scan pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_EMPTY;
      mode_q_r <= MODE_DIRECT;
      ptr_r    <= '0;
    end else begin
      state_r  <= state_s;
      mode_q_r <= mode;
      if (capture_s && scan_s) begin
        ptr_r <= next_ptr_s;
      end
    end
  end

  // Output sample registers; sel_err is a single-cycle pulse per bad capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r    <= '0;
      dout_ch_r <= '0;
      sel_err_r <= 1'b0;
    end else if (capture_s) begin
      dout_r    <= data_s;
      dout_ch_r <= pick_ch_s;
      sel_err_r <= oor_s;
    end else begin
      sel_err_r <= 1'b0;
    end
  end

  assign in_ready  = ready_s;
  assign dout      = dout_r;
  assign dout_ch   = dout_ch_r;
  assign out_valid = (state_r == ST_FULL);
  assign sel_err   = sel_err_r;

endmodule

// File: tb/tb_sel_mux_scan.sv
// Self-checking bench for sel_mux_scan: 8-channel instance against a reference
// model, plus a 6-channel instance for the out-of-range select path.
module tb_sel_mux_scan;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [31:0] din8;
  logic [2:0]  sel8, ch8;
  logic        mode8, iv8, ir8, ov8, or8, err8;
  logic [3:0]  dout8;

  logic [23:0] din6;
  logic [2:0]  sel6, ch6;
  logic        mode6, iv6, ir6, ov6, or6, err6;
  logic [3:0]  dout6;

`ifdef SEL_SCAN_MASK_EN
  logic [7:0]  mask8;
  logic [5:0]  mask6;
`endif

  int nchecks = 0;
  int nerrors = 0;

  // reference model state for the 8-channel instance
  int         m_ptr;
  logic       m_prev, m_valid, m_err;
  logic [3:0] m_dout;
  logic [2:0] m_ch;

  always #5 clk = ~clk;

  sel_mux_scan #(.WIDTH(4), .CHANNELS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .din(din8), .sel_in(sel8), .mode(mode8),
    .in_valid(iv8), .in_ready(ir8), .dout(dout8), .dout_ch(ch8),
    .out_valid(ov8), .out_ready(or8),
`ifdef SEL_SCAN_MASK_EN
    .ch_mask(mask8),
`endif
    .sel_err(err8)
  );

  sel_mux_scan #(.WIDTH(4), .CHANNELS(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .din(din6), .sel_in(sel6), .mode(mode6),
    .in_valid(iv6), .in_ready(ir6), .dout(dout6), .dout_ch(ch6),
    .out_valid(ov6), .out_ready(or6),
`ifdef SEL_SCAN_MASK_EN
    .ch_mask(mask6),
`endif
    .sel_err(err6)
  );

  function automatic logic [7:0] cur_mask();
`ifdef SEL_SCAN_MASK_EN
    return mask8;
`else
    return 8'hFF;
`endif
  endfunction

  function automatic int lowest_set(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int next_set(input int c, input logic [7:0] m);
    for (int k = 1; k <= 8; k++) if (m[(c + k) % 8]) return (c + k) % 8;
    return c;
  endfunction

  function automatic logic model_ready();
    return (!m_valid || or8) && !(mode8 && (cur_mask() == 8'h00));
  endfunction

  task automatic m_reset();
    m_ptr = 0; m_prev = 1'b0; m_valid = 1'b0; m_err = 1'b0;
    m_dout = 4'd0; m_ch = 3'd0;
  endtask

  // advance the model by one clock using the inputs currently applied
  task automatic model_clock();
    int  ch;
    logic cap;
    cap = iv8 && model_ready();
    if (mode8) ch = (m_prev == 1'b0) ? lowest_set(cur_mask()) : m_ptr;
    else       ch = int'(sel8);
    if (cap) begin
      m_valid = 1'b1;
      m_ch    = 3'(ch);
      m_dout  = din8[ch*4 +: 4];
      m_err   = 1'b0;
      if (mode8) m_ptr = next_set(ch, cur_mask());
    end else begin
      m_err = 1'b0;
      if (or8) m_valid = 1'b0;
    end
    m_prev = mode8;
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_ramp();
    for (int k = 0; k < 8; k++) din8[k*4 +: 4] = 4'(k);
    for (int k = 0; k < 6; k++) din6[k*4 +: 4] = 4'(k);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    din8 = 32'd0; sel8 = 3'd0; mode8 = 1'b0; iv8 = 1'b0; or8 = 1'b1;
    din6 = 24'd0; sel6 = 3'd0; mode6 = 1'b0; iv6 = 1'b0; or6 = 1'b1;
`ifdef SEL_SCAN_MASK_EN
    mask8 = 8'hFF; mask6 = 6'h3F;
`endif
    m_reset();
    repeat (2) @(negedge clk);
    nchecks++; if (dout8 !== 4'd0) begin nerrors++; $display("FAIL reset_dout got %0h want 0", dout8); end
    nchecks++; if (ch8 !== 3'd0) begin nerrors++; $display("FAIL reset_ch got %0d want 0", ch8); end
    nchecks++; if (ov8 !== 1'b0) begin nerrors++; $display("FAIL reset_valid got %b want 0", ov8); end
    nchecks++; if (err8 !== 1'b0) begin nerrors++; $display("FAIL reset_err got %b want 0", err8); end
    rst_n = 1'b1;
    #1;
    nchecks++; if (ir8 !== 1'b1) begin nerrors++; $display("FAIL reset_ready got %b want 1", ir8); end
  endtask

  task automatic test_direct();
    load_ramp();
    mode8 = 1'b0; sel8 = 3'd5; iv8 = 1'b1; or8 = 1'b1;
    tick();
    nchecks++; if (dout8 !== 4'd5) begin nerrors++; $display("FAIL direct_dout got %0h want 5", dout8); end
    nchecks++; if (ch8 !== 3'd5) begin nerrors++; $display("FAIL direct_ch got %0d want 5", ch8); end
    nchecks++; if (ov8 !== 1'b1) begin nerrors++; $display("FAIL direct_valid got %b want 1", ov8); end
    nchecks++; if (err8 !== 1'b0) begin nerrors++; $display("FAIL direct_err got %b want 0", err8); end
  endtask

  task automatic test_scan_wrap();
    mode8 = 1'b1; iv8 = 1'b1; or8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      nchecks++;
      if (dout8 !== 4'(i % 8) || ch8 !== 3'(i % 8)) begin
        nerrors++; $display("FAIL scan_wrap step %0d got dout=%0d ch=%0d want %0d", i, dout8, ch8, i % 8);
      end
    end
  endtask

  task automatic test_stall();
    mode8 = 1'b0; sel8 = 3'd5; iv8 = 1'b1; or8 = 1'b1;
    tick();
    mode8 = 1'b1;
    tick();
    nchecks++; if (dout8 !== 4'd0) begin nerrors++; $display("FAIL stall_first got %0d want 0", dout8); end
    or8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      nchecks++; if (ir8 !== 1'b0) begin nerrors++; $display("FAIL stall_ready got %b want 0", ir8); end
      tick();
      nchecks++;
      if (dout8 !== 4'd0 || ov8 !== 1'b1) begin
        nerrors++; $display("FAIL stall_hold got dout=%0d valid=%b want 0/1", dout8, ov8);
      end
    end
    or8 = 1'b1;
    tick();
    nchecks++; if (dout8 !== 4'd1) begin nerrors++; $display("FAIL stall_release got %0d want 1", dout8); end
  endtask

  task automatic test_range();
    iv8 = 1'b0; or8 = 1'b1;
    mode6 = 1'b0; sel6 = 3'd7; iv6 = 1'b1; or6 = 1'b1;
    tick();
    nchecks++;
    if (dout6 !== 4'd0 || ch6 !== 3'd7 || ov6 !== 1'b1 || err6 !== 1'b1) begin
      nerrors++; $display("FAIL range_sel7 got dout=%0d ch=%0d valid=%b err=%b want 0/7/1/1", dout6, ch6, ov6, err6);
    end
    sel6 = 3'd5;
    tick();
    nchecks++;
    if (dout6 !== 4'd5 || err6 !== 1'b0) begin
      nerrors++; $display("FAIL range_sel5 got dout=%0d err=%b want 5/0", dout6, err6);
    end
    sel6 = 3'd6;
    tick();
    nchecks++;
    if (dout6 !== 4'd0 || err6 !== 1'b1) begin
      nerrors++; $display("FAIL range_sel6 got dout=%0d err=%b want 0/1", dout6, err6);
    end
    iv6 = 1'b0;
    tick();
    nchecks++; if (err6 !== 1'b0) begin nerrors++; $display("FAIL range_pulse got err=%b want 0", err6); end
  endtask

  task automatic test_reset_mid();
    load_ramp();
    mode8 = 1'b0; sel8 = 3'd1; iv8 = 1'b1; or8 = 1'b1;
    tick();
    mode8 = 1'b1;
    repeat (4) tick();
    nchecks++; if (dout8 !== 4'd3 || ov8 !== 1'b1) begin nerrors++; $display("FAIL mid_pre got dout=%0d valid=%b want 3/1", dout8, ov8); end
    #2 rst_n = 1'b0;
    #1;
    nchecks++;
    if (ov8 !== 1'b0 || dout8 !== 4'd0) begin
      nerrors++; $display("FAIL mid_reset got dout=%0d valid=%b want 0/0", dout8, ov8);
    end
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    nchecks++; if (dout8 !== 4'd0 || ch8 !== 3'd0) begin nerrors++; $display("FAIL mid_restart got ch=%0d want 0", ch8); end
    tick();
    nchecks++; if (dout8 !== 4'd1) begin nerrors++; $display("FAIL mid_second got %0d want 1", dout8); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      din8 = $urandom;
      if ($urandom_range(3, 0) == 0) mode8 = ~mode8;
      sel8 = 3'($urandom_range(7, 0));
      iv8  = ($urandom_range(3, 0) != 0);
      or8  = ($urandom_range(2, 0) != 0);
`ifdef SEL_SCAN_MASK_EN
      if ($urandom_range(7, 0) == 0) mask8 = 8'($urandom_range(255, 0));
      if ($urandom_range(15, 0) == 0) mask8 = 8'h00;
`endif
      #1;
      nchecks++; if (ir8 !== model_ready()) begin nerrors++; $display("FAIL rand_ready cyc %0d got %b want %b", i, ir8, model_ready()); end
      tick();
      nchecks++;
      if (ov8 !== m_valid || err8 !== m_err) begin
        nerrors++; $display("FAIL rand_flags cyc %0d got valid=%b err=%b want %b/%b", i, ov8, err8, m_valid, m_err);
      end
      nchecks++;
      if (dout8 !== m_dout || ch8 !== m_ch) begin
        nerrors++; $display("FAIL rand_data cyc %0d got dout=%0h ch=%0d want %0h/%0d", i, dout8, ch8, m_dout, m_ch);
      end
    end
  endtask

`ifdef SEL_SCAN_MASK_EN
  task automatic test_mask();
    int exp_seq [4] = '{2, 5, 7, 2};
    load_ramp();
    mask8 = 8'b1010_0100;
    mode8 = 1'b0; sel8 = 3'd0; iv8 = 1'b1; or8 = 1'b1;
    tick();
    mode8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      nchecks++;
      if (ch8 !== 3'(exp_seq[i]) || dout8 !== 4'(exp_seq[i])) begin
        nerrors++; $display("FAIL mask_order step %0d got ch=%0d want %0d", i, ch8, exp_seq[i]);
      end
    end
    mask8 = 8'h00;
    #1;
    nchecks++; if (ir8 !== 1'b0) begin nerrors++; $display("FAIL mask_zero_ready got %b want 0", ir8); end
    tick();
    nchecks++; if (ov8 !== 1'b0) begin nerrors++; $display("FAIL mask_zero_valid got %b want 0", ov8); end
    mask8 = 8'hFF;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_direct();
    test_scan_wrap();
    test_stall();
    test_range();
    test_reset_mid();
`ifdef SEL_SCAN_MASK_EN
    test_mask();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
